// File: rtl/init_memory_block_pkg.sv
// rtl/init_memory_block_pkg.sv - shared types, limits and byte-merge helper for the init-clear memory
package mem_pkg;

    typedef enum logic [0:0] {ST_INIT, ST_RUN} mem_state_t;

    localparam int MEM_MAX_RD_LAT = 2;

    // Widest word the merge helper handles; callers zero-extend into it and cast back down.
    localparam int MEM_MAX_DATAW = 512;
    localparam int MEM_MAX_BEW   = MEM_MAX_DATAW / 8;

    function automatic logic [MEM_MAX_DATAW-1:0] byte_merge(
        input logic [MEM_MAX_DATAW-1:0] old_word,
        input logic [MEM_MAX_DATAW-1:0] new_word,
        input logic [MEM_MAX_BEW-1:0]   be
    );
        logic [MEM_MAX_DATAW-1:0] merged;
        for (int i = 0; i < MEM_MAX_BEW; i++) begin
            merged[8*i +: 8] = be[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/init_memory_block_if.sv
// rtl/init_memory_block_if.sv - write/read command and response bundle of the init-clear memory
interface init_memory_block_if #(
    parameter int DATAW = 32,
    parameter int ADDRW = 6
);
    logic               ready;
    logic [ADDRW-1:0]   waddr;
    logic               wen;
    logic [DATAW/8-1:0] wbe;
    logic [DATAW-1:0]   wdata;
    logic [ADDRW-1:0]   raddr;
    logic               ren;
    logic [DATAW-1:0]   rdata;
    logic               rvalid;

    modport master (
        input  ready, rdata, rvalid,
        output waddr, wen, wbe, wdata, raddr, ren
    );

    modport slave (
        output ready, rdata, rvalid,
        input  waddr, wen, wbe, wdata, raddr, ren
    );
endinterface

// File: rtl/init_memory_block_rd_pipe.sv
// rtl/init_memory_block_rd_pipe.sv - RD_LAT-deep {valid, data} read pipeline, flushed by rst
module mem_rd_pipe #(
    parameter int RD_LAT = 1,
    parameter int DATAW  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [DATAW-1:0] in_data,
    output logic             out_valid,
    output logic [DATAW-1:0] out_data
);
    logic [RD_LAT-1:0] valid_q;
    logic [DATAW-1:0]  data_q [RD_LAT];

    // Data stages load only behind a valid, so the last stage holds between strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < RD_LAT; i++) data_q[i] <= '0;
        end else begin
            valid_q[0] <= in_valid;
            if (in_valid) data_q[0] <= in_data;
            for (int i = 1; i < RD_LAT; i++) begin
                valid_q[i] <= valid_q[i-1];
                if (valid_q[i-1]) data_q[i] <= data_q[i-1];
            end
        end
    end

    assign out_valid = valid_q[RD_LAT-1];
    assign out_data  = data_q[RD_LAT-1];
endmodule

// File: rtl/init_memory_block.sv
// rtl/init_memory_block.sv - 1W/1R byte-masked memory that self-clears after reset
// MEM_BYPASS_EN: same-cycle same-address read returns the merged write word (write-first).
module init_memory_block
    import mem_pkg::*;
#(
    parameter int DATAW  = 32,
    parameter int DEPTH  = 64,
    parameter int ADDRW  = $clog2(DEPTH),
    parameter int RD_LAT = 1
) (
    input  logic clk,
    input  logic rst,
    init_memory_block_if.slave mem_if
);
    localparam logic [ADDRW:0] LAST_ADDR = (ADDRW+1)'(DEPTH - 1);

    mem_state_t       state_q, state_d;
    logic [ADDRW:0]   init_cnt_q;
    logic             run, clr_we;
    logic             wr_in_range, rd_in_range, wr_en;
    logic [DATAW-1:0] wr_merged, rd_data_in;
    logic [DATAW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_INIT;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (state_q == ST_INIT && init_cnt_q == LAST_ADDR) state_d = ST_RUN;
    end

    always_comb begin
        run    = 1'b0;
        clr_we = 1'b0;
        case (state_q)
            ST_INIT: clr_we = 1'b1;
            ST_RUN:  run    = 1'b1;
            default: ;
        endcase
    end

    assign mem_if.ready = run;

    // One bit wider than the address so DEPTH == 2**ADDRW counts through without wrapping.
    always_ff @(posedge clk) begin
        if (rst)         init_cnt_q <= '0;
        else if (clr_we) init_cnt_q <= init_cnt_q + 1'b1;
    end

    generate
        if (DEPTH == (1 << ADDRW)) begin : g_full
            assign wr_in_range = 1'b1;
            assign rd_in_range = 1'b1;
        end else begin : g_partial
            assign wr_in_range = mem_if.waddr < ADDRW'(DEPTH);
            assign rd_in_range = mem_if.raddr < ADDRW'(DEPTH);
        end
    endgenerate

    assign wr_en     = run && !rst && mem_if.wen && wr_in_range;
    assign wr_merged = DATAW'(byte_merge(MEM_MAX_DATAW'(mem[mem_if.waddr]),
                                         MEM_MAX_DATAW'(mem_if.wdata),
                                         MEM_MAX_BEW'(mem_if.wbe)));

    always_ff @(posedge clk) begin
        if (clr_we)     mem[init_cnt_q[ADDRW-1:0]] <= '0;
        else if (wr_en) mem[mem_if.waddr]          <= wr_merged;
    end

    // Array read sees pre-write contents; the bypass substitutes the merged word instead.
    always_comb begin
        rd_data_in = '0;
        if (rd_in_range) begin
            rd_data_in = mem[mem_if.raddr];
`ifdef MEM_BYPASS_EN
            if (wr_en && mem_if.waddr == mem_if.raddr) rd_data_in = wr_merged;
`else
`endif
        end
    end

    mem_rd_pipe #(
        .RD_LAT (RD_LAT),
        .DATAW  (DATAW)
    ) u_rd_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (run && mem_if.ren),
        .in_data   (rd_data_in),
        .out_valid (mem_if.rvalid),
        .out_data  (mem_if.rdata)
    );
endmodule

// File: tb/tb_init_memory_block.sv
// tb/tb_init_memory_block.sv - bench for init_memory_block: 64-deep RD_LAT=1 and 48-deep RD_LAT=2 side by side
module tb_init_memory_block;

    typedef struct {
        bit          wen;
        logic [5:0]  waddr;
        logic [3:0]  wbe;
        logic [31:0] wdata;
        bit          ren;
        logic [5:0]  raddr;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

`ifdef MEM_BYPASS_EN
    localparam logic [31:0] COL_FULL = 32'h12345678;
    localparam logic [31:0] COL_PART = 32'h12BBCC78;
`else
    localparam logic [31:0] COL_FULL = 32'hCAFEF00D;
    localparam logic [31:0] COL_PART = 32'h12345678;
`endif

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    bit   mon_on = 1'b0;
    exp_t q_a[$];
    exp_t q_b[$];
    exp_t ea, eb;
    bit   ev_a, ev_b;
    vec_t vecs[$];
    int   first_a, first_b;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    init_memory_block_if #(.DATAW(32), .ADDRW(6)) if_a ();
    init_memory_block_if #(.DATAW(32), .ADDRW(6)) if_b ();

    init_memory_block #(.DATAW(32), .DEPTH(64), .ADDRW(6), .RD_LAT(1)) dut_a (
        .clk (clk), .rst (rst), .mem_if (if_a)
    );
    init_memory_block #(.DATAW(32), .DEPTH(48), .ADDRW(6), .RD_LAT(2)) dut_b (
        .clk (clk), .rst (rst), .mem_if (if_b)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    endtask

    function automatic vec_t v(bit wen, logic [5:0] wa, logic [3:0] be, logic [31:0] wd,
                               bit ren, logic [5:0] ra, logic [31:0] xa, logic [31:0] xb);
        vec_t r;
        r.wen = wen; r.waddr = wa; r.wbe = be; r.wdata = wd;
        r.ren = ren; r.raddr = ra; r.exp_a = xa; r.exp_b = xb;
        return r;
    endfunction

    task automatic drive(input vec_t x);
        if_a.wen = x.wen; if_a.waddr = x.waddr; if_a.wbe = x.wbe; if_a.wdata = x.wdata;
        if_a.ren = x.ren; if_a.raddr = x.raddr;
        if_b.wen = x.wen; if_b.waddr = x.waddr; if_b.wbe = x.wbe; if_b.wdata = x.wdata;
        if_b.ren = x.ren; if_b.raddr = x.raddr;
    endtask

    task automatic apply(input vec_t x);
        exp_t e;
        @(negedge clk);
        drive(x);
        if (x.ren) begin
            e.data = x.exp_a; e.cyc = cyc + 1; q_a.push_back(e);
            e.data = x.exp_b; e.cyc = cyc + 2; q_b.push_back(e);
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) apply(v(0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    task automatic wait_ready(output int fa, output int fb);
        fa = -1; fb = -1;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (if_a.ready && fa < 0) fa = k;
            if (if_b.ready && fb < 0) fb = k;
            // Commands during init must be ignored by both memories.
            if (k <= 40) drive(v(1, 6'd31, 4'hF, 32'hFFFF_FFFF, 1, 6'd0, 0, 0));
            else         drive(v(0, 0, 0, 0, 0, 0, 0, 0));
            if (fa > 0 && fb > 0) break;
        end
    endtask

    // Every cycle: rvalid must match whether a result is due now, and due results must match.
    always @(negedge clk) begin
        if (mon_on) begin
            ev_a = (q_a.size() > 0) && (q_a[0].cyc == cyc);
            check("rvalid_a", 32'(if_a.rvalid), 32'(ev_a));
            if (ev_a) begin
                ea = q_a.pop_front();
                check("rdata_a", if_a.rdata, ea.data);
            end
            ev_b = (q_b.size() > 0) && (q_b[0].cyc == cyc);
            check("rvalid_b", 32'(if_b.rvalid), 32'(ev_b));
            if (ev_b) begin
                eb = q_b.pop_front();
                check("rdata_b", if_b.rdata, eb.data);
            end
        end
    end

    initial begin
        rst = 1'b1;
        drive(v(0, 0, 0, 0, 0, 0, 0, 0));
        repeat (2) @(negedge clk);
        check("reset_ready_a",  32'(if_a.ready),  0);
        check("reset_rvalid_a", 32'(if_a.rvalid), 0);
        check("reset_rdata_a",  if_a.rdata,       0);
        check("reset_ready_b",  32'(if_b.ready),  0);
        check("reset_rvalid_b", 32'(if_b.rvalid), 0);
        check("reset_rdata_b",  if_b.rdata,       0);
        mon_on = 1'b1;
        rst = 1'b0;

        wait_ready(first_a, first_b);
        check("ready_rise_a", 32'(first_a), 64);
        check("ready_rise_b", 32'(first_b), 48);

        vecs.push_back(v(0, 0,  0,    0,            1, 0,  32'h0, 32'h0));
        vecs.push_back(v(0, 0,  0,    0,            1, 31, 32'h0, 32'h0));
        vecs.push_back(v(0, 0,  0,    0,            1, 63, 32'h0, 32'h0));
        vecs.push_back(v(0, 0,  0,    0,            1, 47, 32'h0, 32'h0));
        vecs.push_back(v(1, 5,  4'hF, 32'hDEADBEEF, 0, 0,  0, 0));
        vecs.push_back(v(1, 5,  4'h1, 32'h000000AA, 0, 0,  0, 0));
        vecs.push_back(v(0, 0,  0,    0,            1, 5,  32'hDEADBEAA, 32'hDEADBEAA));
        vecs.push_back(v(1, 1,  4'hF, 32'h11,       0, 0,  0, 0));
        vecs.push_back(v(1, 2,  4'hF, 32'h22,       0, 0,  0, 0));
        vecs.push_back(v(1, 3,  4'hF, 32'h33,       0, 0,  0, 0));
        vecs.push_back(v(1, 4,  4'hF, 32'h44,       0, 0,  0, 0));
        vecs.push_back(v(0, 0,  0,    0,            1, 1,  32'h11, 32'h11));
        vecs.push_back(v(0, 0,  0,    0,            1, 2,  32'h22, 32'h22));
        vecs.push_back(v(0, 0,  0,    0,            1, 3,  32'h33, 32'h33));
        vecs.push_back(v(0, 0,  0,    0,            1, 4,  32'h44, 32'h44));
        vecs.push_back(v(1, 9,  4'hF, 32'hCAFEF00D, 0, 0,  0, 0));
        vecs.push_back(v(1, 9,  4'hF, 32'h12345678, 1, 9,  COL_FULL, COL_FULL));
        vecs.push_back(v(0, 0,  0,    0,            1, 9,  32'h12345678, 32'h12345678));
        vecs.push_back(v(1, 9,  4'h6, 32'hAABBCCDD, 1, 9,  COL_PART, COL_PART));
        vecs.push_back(v(0, 0,  0,    0,            1, 9,  32'h12BBCC78, 32'h12BBCC78));
        vecs.push_back(v(1, 47, 4'hF, 32'h47474747, 0, 0,  0, 0));
        vecs.push_back(v(1, 50, 4'hF, 32'h50505050, 0, 0,  0, 0));
        vecs.push_back(v(0, 0,  0,    0,            1, 50, 32'h50505050, 32'h0));
        vecs.push_back(v(0, 0,  0,    0,            1, 47, 32'h47474747, 32'h47474747));
        vecs.push_back(v(1, 47, 4'h0, 32'hFFFFFFFF, 0, 0,  0, 0));
        vecs.push_back(v(0, 0,  0,    0,            1, 47, 32'h47474747, 32'h47474747));
        vecs.push_back(v(0, 0,  0,    0,            1, 2,  32'h22, 32'h22));
        foreach (vecs[i]) apply(vecs[i]);
        idle_cycles(4);

        // Reset one cycle after a read: the 1-cycle memory has already answered, the 2-cycle one must not.
        begin
            exp_t e;
            @(negedge clk);
            drive(v(0, 0, 0, 0, 1, 5, 0, 0));
            e.data = 32'hDEADBEAA; e.cyc = cyc + 1; q_a.push_back(e);
            @(negedge clk);
            drive(v(0, 0, 0, 0, 0, 0, 0, 0));
            rst = 1'b1;
            @(negedge clk);
            check("midrst_ready_a",  32'(if_a.ready),  0);
            check("midrst_ready_b",  32'(if_b.ready),  0);
            check("midrst_rdata_a",  if_a.rdata,       0);
            check("midrst_rdata_b",  if_b.rdata,       0);
            rst = 1'b0;
        end
        wait_ready(first_a, first_b);
        check("reinit_rise_a", 32'(first_a), 64);
        check("reinit_rise_b", 32'(first_b), 48);
        apply(v(0, 0, 0, 0, 1, 5,  32'h0, 32'h0));
        apply(v(0, 0, 0, 0, 1, 9,  32'h0, 32'h0));
        apply(v(0, 0, 0, 0, 1, 47, 32'h0, 32'h0));
        idle_cycles(4);

        check("sb_empty_a", 32'(q_a.size()), 0);
        check("sb_empty_b", 32'(q_b.size()), 0);
        mon_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
